// File: rtl/shift_add_mul_ctrl.sv
// Sequential shift-add multiplier: one multiplier bit per clock,
// multiplicand read live from an upstream PIPO register.
module shift_add_mul_ctrl #(
  parameter int N     = 16,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   mplier,
  input  logic [N-1:0]   mcand_in,
  output logic           ld_mcand,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   prod_q, prod_d;

  logic [N:0]       sum;
  logic [2*N-1:0]   shr;
  logic             last;
  logic             idle;

  // {C,A} sum, then {C,A,Q} >> 1 drops Q[0] and keeps the carry
  always_comb begin
    sum  = {1'b0, a_q} + (q_q[0] ? {1'b0, mcand_in} : '0);
    shr  = {sum, q_q[N-1:1]};
    last = (cnt_q == CNT_W'(N-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = mplier;
          a_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = shr[2*N-1:N];
        q_d   = shr[N-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = DONE;
          prod_d  = shr;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the idle-facing view even before the first edge
  assign idle     = (state_q == IDLE);
  assign ready    = rst | idle;
  assign busy     = ~rst & (state_q == CALC);
  assign done     = ~rst & (state_q == DONE);
  assign ld_mcand = ~rst & idle & start;
  assign product  = prod_q;

endmodule
